// File: rtl/four_bit_multiplier.sv
// Unsigned 4x4 -> 8-bit array multiplier with a registered product.
// Partial products are summed by three rows of 4-bit ripple-carry adders.
module four_bit_multiplier (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] c,
  output logic       out_valid
);

  logic [3:0][3:0] pp;
  logic [4:0]      row1;
  logic [4:0]      row2;
  logic [4:0]      row3;
  logic [7:0]      product;
  logic [7:0]      c_d;
  logic [7:0]      c_q;
  logic            out_valid_d;
  logic            out_valid_q;

  // Returns {carry_out, sum[3:0]} of a 4-bit ripple adder with carry-in 0.
  function automatic logic [4:0] ripple4(input logic [3:0] x, input logic [3:0] y);
    logic       carry;
    logic [3:0] sum;
    carry = 1'b0;
    sum   = 4'h0;
    for (int k = 0; k < 4; k++) begin
      sum[k] = x[k] ^ y[k] ^ carry;
      carry  = (x[k] & y[k]) | ((x[k] ^ y[k]) & carry);
    end
    return {carry, sum};
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pp[i] = b & {4{a[i]}};
    end
    row1    = ripple4({1'b0, pp[0][3:1]}, pp[1]);
    row2    = ripple4({row1[4], row1[3:1]}, pp[2]);
    row3    = ripple4({row2[4], row2[3:1]}, pp[3]);
    product = {row3, row2[0], row1[0], pp[0][0]};
  end

  always_comb begin
    c_d         = c_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      c_d         = product;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q         <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign c         = c_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_four_bit_multiplier.sv
// Scoreboard bench for four_bit_multiplier: the driver pushes the expected
// registered outputs, a monitor pops and compares them after each edge.
module tb_four_bit_multiplier;

  typedef struct {
    logic [7:0] c;
    logic       v;
  } expect_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] c;
  logic       out_valid;

  expect_t    sb_q[$];
  int         check_count;
  int         fail_count;
  logic [7:0] model_c;
  logic       model_v;

  four_bit_multiplier dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs and predicts what the registers hold after the edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [3:0] x, input logic [3:0] y);
    expect_t e;
    rst      = r;
    in_valid = v;
    a        = x;
    b        = y;
    if (r) begin
      model_c = 8'h00;
      model_v = 1'b0;
    end else if (v) begin
      model_c = 8'(int'(x) * int'(y));
      model_v = 1'b1;
    end else begin
      model_v = 1'b0;
    end
    e.c = model_c;
    e.v = model_v;
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    expect_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checkOutput("c", int'(c), int'(e.c));
      checkOutput("out_valid", int'(out_valid), int'(e.v));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    check_count = 0;
    fail_count  = 0;
    model_c     = 8'h00;
    model_v     = 1'b0;

    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0);
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0);

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        applyStimulus(1'b0, 1'b1, 4'(i), 4'(j));
      end
    end

    applyStimulus(1'b0, 1'b1, 4'd15, 4'd15);
    applyStimulus(1'b0, 1'b1, 4'd0,  4'd13);
    applyStimulus(1'b0, 1'b1, 4'd1,  4'd9);
    applyStimulus(1'b0, 1'b1, 4'd8,  4'd8);
    applyStimulus(1'b0, 1'b1, 4'd15, 4'd1);

    applyStimulus(1'b0, 1'b1, 4'd7, 4'd6);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 4'd2, 4'd2);
    end

    applyStimulus(1'b1, 1'b1, 4'd5, 4'd5);
    applyStimulus(1'b0, 1'b1, 4'd5, 4'd5);

    applyStimulus(1'b0, 1'b1, 4'd9, 4'd9);
    applyStimulus(1'b1, 1'b1, 4'd4, 4'd4);
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);

    applyStimulus(1'b0, 1'b1, 4'd12, 4'd11);
    applyStimulus(1'b0, 1'b1, 4'd3,  4'd14);
    applyStimulus(1'b0, 1'b1, 4'd10, 4'd10);
    applyStimulus(1'b0, 1'b0, 4'd0,  4'd0);

    checkOutput("scoreboard_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/four_bit_multiplier.md
Name: four_bit_multiplier

Overview:
Unsigned 4x4 -> 8-bit array multiplier with a registered result. The block forms the product combinationally from AND-gate partial products summed by rows of ripple-carry full/half adders. It captures the result in an output register on the clock edge. It is a leaf arithmetic block used wherever a small unsigned product is needed within one clock of operand presentation.

Parameters:
None. Widths are fixed: operands 4 bits, product 8 bits.

Ports:
clk        input   1  system clock; all state updates on rising edge
rst        input   1  synchronous, active-high reset
in_valid   input   1  operands a/b valid this cycle; product is captured when high
a          input   4  multiplicand, unsigned
b          input   4  multiplier, unsigned
c          output  8  registered product a*b, unsigned
out_valid  output  1  high for one cycle when c holds a newly captured product

Behaviour:
- Arithmetic: c = a * b, unsigned, full precision. Range is 0..225 (15*15), so overflow cannot occur. No sign extension and no truncation.
- Datapath structure (combinational core):
  - 16 partial products pp[i][j] = a[i] & b[j].
  - Product bit 0 = pp[0][0].
  - Row 1: 4-bit ripple adder sums {0, pp[0][3:1]} with pp[1][3:0], carry-in 0. Its sum bit 0 is product bit 1.
  - Row 2: sums {row1 carry-out, row1 sum[3:1]} with pp[2][3:0]. Its sum bit 0 is product bit 2.
  - Row 3: sums {row2 carry-out, row2 sum[3:1]} with pp[3][3:0]. Its sum[3:0] gives product bits 6:3, and its carry-out gives product bit 7.
  - Each full adder: sum = x^y^ci, carry = (x&y)|((x^y)&ci).
- Latency: 1 clock. Operands sampled at rising edge N with in_valid=1 produce c = a*b and out_valid=1 after edge N.
- in_valid=0 at an edge: c holds its previous value; out_valid=0.
- Back-to-back: a new product is accepted on every cycle that in_valid=1. There is no stall and no backpressure, and out_valid stays high continuously.
- Reset: when rst=1 at a rising edge, c=8'h00 and out_valid=0, regardless of in_valid. rst has priority.
  - If reset is asserted mid-stream, the pending product is discarded.
  - The first edge with rst=0 and in_valid=1 produces a valid output normally.
- Outputs come directly from flops; there is no combinational path from inputs to outputs.
- X/undriven operands are not required to be handled. The operand inputs are assumed to be driven whenever in_valid=1.

Test Plan:
- Exhaustive sweep: a=0..15 (outer loop), b=0..15 (inner loop), in_valid=1 one pair per cycle. Each c must equal a*b one cycle later with out_valid=1. Example row a=3 reads 0,3,6,...,45.
- Corners: a=15,b=15 -> c=225 (8'hE1); a=0,b=13 -> 0; a=1,b=9 -> 9; a=8,b=8 -> 64 (8'h40); a=15,b=1 -> 15.
- Hold: capture 7*6=42, then drop in_valid and change a=2,b=2 for 3 cycles. c must stay 42 and out_valid must be 0.
- Reset priority: assert rst with in_valid=1, a=5, b=5. Next cycle c=0 and out_valid=0. Release rst, and the next captured product is 25.
- Reset mid-stream: feed 9*9 then 4*4 consecutively, with rst high on the edge that captures 4*4. c must be 0 rather than 16, and out_valid must be 0.
- Back-to-back: pairs (12,11), (3,14), (10,10) on consecutive cycles. c must read 132, 42, 100 on consecutive cycles with out_valid held high.
